dmem_bus_arbiter: RTL and testbench

- Two-requester arbiter for the single data-memory / memory-mapped I/O port (DataMemory, including KEY/SW/HEX/LEDR/LEDG at 0xF0000000-0xF0000014).
- Requester 0 is the CPU datapath; requester 1 is a secondary master (debug loader or DMA).
- Registers the winning command, drives the shared port, and returns read data with a valid pulse.
- Round-robin fairness; fixed-latency memory with 1-cycle read latency.

---
 rtl/dmem_bus_arbiter_if.sv | 28 ++
 rtl/dmem_bus_arbiter.sv | 99 +++++++++
 tb/tb_dmem_bus_arbiter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_bus_arbiter_if.sv
// dmem_bus_arbiter_if: bus bundle between the two requesters, the data-memory port and the arbiter.
//   requester side : req0/1, we0/1, addr0/1, wdata0/1 in; gnt0/1, rvalid0/1, rdata0/1 out
//   memory side    : mem_en, mem_we, mem_addr, mem_wdata out; mem_rdata in
//   status         : busy, gcnt0, gcnt1, ccnt
//   modport slave  is the arbiter view; modport master is the requester/memory view.
interface dmem_bus_arbiter_if #(
   parameter int DBITS    = 32,
   parameter int CNT_BITS = 16
);
   logic                req0, req1, we0, we1;
   logic [DBITS-1:0]    addr0, addr1, wdata0, wdata1;
   logic                gnt0, gnt1, rvalid0, rvalid1;
   logic [DBITS-1:0]    rdata0, rdata1;
   logic                mem_en, mem_we;
   logic [DBITS-1:0]    mem_addr, mem_wdata, mem_rdata;
   logic                busy;
   logic [CNT_BITS-1:0] gcnt0, gcnt1, ccnt;
   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
      output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
      output mem_en, mem_we, mem_addr, mem_wdata, busy, gcnt0, gcnt1, ccnt
   );
   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
      input  mem_en, mem_we, mem_addr, mem_wdata, busy, gcnt0, gcnt1, ccnt
   );
endinterface

// File: rtl/dmem_bus_arbiter.sv
// dmem_bus_arbiter: round-robin two-requester arbiter for the data-memory / MMIO port.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : dmem_bus_arbiter_if.slave (requester handshakes, memory port, busy, counters)
//   Optional grant/conflict counters are built when ARB_PERF_CNT_EN is defined.
module dmem_bus_arbiter #(
   parameter int DBITS    = 32,
   parameter int CNT_BITS = 16
) (
   input logic               clk,
   input logic               reset,
   dmem_bus_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;
   state_t           state, state_n;
   logic             take, win1;
   logic             rr_last, rr_last_n;
   logic             mem_en_q, mem_en_n, mem_we_q, mem_we_n;
   logic             gnt0_q, gnt0_n, gnt1_q, gnt1_n;
   logic             rvalid0_q, rvalid0_n, rvalid1_q, rvalid1_n;
   logic             busy_q, busy_n;
   logic [DBITS-1:0] mem_addr_q, mem_addr_n, mem_wdata_q, mem_wdata_n;
   // rr_last doubles as the owner of the command in flight, since it is set to the winner.
   always_comb begin
      take        = (state == IDLE) && (bus.req0 || bus.req1);
      win1        = bus.req1 && (!bus.req0 || !rr_last);
      state_n     = (state == IDLE)  ? (take ? ISSUE : IDLE) :
                    (state == ISSUE) ? (mem_we_q ? IDLE : RDWAIT) : IDLE;
      rr_last_n   = take ? win1 : rr_last;
      mem_en_n    = take;
      gnt0_n      = take && !win1;
      gnt1_n      = take && win1;
      mem_we_n    = take ? (win1 ? bus.we1 : bus.we0) : mem_we_q;
      mem_addr_n  = take ? (win1 ? bus.addr1 : bus.addr0) : mem_addr_q;
      mem_wdata_n = take ? (win1 ? bus.wdata1 : bus.wdata0) : mem_wdata_q;
      rvalid0_n   = (state == ISSUE) && !mem_we_q && !rr_last;
      rvalid1_n   = (state == ISSUE) && !mem_we_q && rr_last;
      busy_n      = state_n != IDLE;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         rr_last     <= 1'b1;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         gnt0_q      <= 1'b0;
         gnt1_q      <= 1'b0;
         rvalid0_q   <= 1'b0;
         rvalid1_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state       <= state_n;
         rr_last     <= rr_last_n;
         mem_en_q    <= mem_en_n;
         mem_we_q    <= mem_we_n;
         mem_addr_q  <= mem_addr_n;
         mem_wdata_q <= mem_wdata_n;
         gnt0_q      <= gnt0_n;
         gnt1_q      <= gnt1_n;
         rvalid0_q   <= rvalid0_n;
         rvalid1_q   <= rvalid1_n;
         busy_q      <= busy_n;
      end
   end
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.gnt0      = gnt0_q;
   assign bus.gnt1      = gnt1_q;
   assign bus.rvalid0   = rvalid0_q;
   assign bus.rvalid1   = rvalid1_q;
   assign bus.busy      = busy_q;
   // Read data is passed straight through from memory, steered only to the owner.
   assign bus.rdata0    = rvalid0_q ? bus.mem_rdata : '0;
   assign bus.rdata1    = rvalid1_q ? bus.mem_rdata : '0;
`ifdef ARB_PERF_CNT_EN
   logic [CNT_BITS-1:0] gcnt0_q, gcnt1_q, ccnt_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gcnt0_q <= '0;
         gcnt1_q <= '0;
         ccnt_q  <= '0;
      end else begin
         if (gnt0_n && !(&gcnt0_q)) gcnt0_q <= gcnt0_q + CNT_BITS'(1);
         if (gnt1_n && !(&gcnt1_q)) gcnt1_q <= gcnt1_q + CNT_BITS'(1);
         if (take && bus.req0 && bus.req1 && !(&ccnt_q)) ccnt_q <= ccnt_q + CNT_BITS'(1);
      end
   end
   assign bus.gcnt0 = gcnt0_q;
   assign bus.gcnt1 = gcnt1_q;
   assign bus.ccnt  = ccnt_q;
`else
   assign bus.gcnt0 = {CNT_BITS{1'b0}};
   assign bus.gcnt1 = {CNT_BITS{1'b0}};
   assign bus.ccnt  = {CNT_BITS{1'b0}};
`endif
endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// tb_dmem_bus_arbiter: directed scoreboard bench for dmem_bus_arbiter.
module tb_dmem_bus_arbiter;
   localparam int DBITS = 32;
   localparam int CNT_BITS = 4;
`ifdef ARB_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif
   typedef struct {
      int               who;
      logic [DBITS-1:0] data;
   } rd_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   e_g0 = 0, e_g1 = 0, e_cc = 0;
   int   who, cyc;
   rd_t  sb[$];
   dmem_bus_arbiter_if #(.DBITS(DBITS), .CNT_BITS(CNT_BITS)) bus ();
   dmem_bus_arbiter #(.DBITS(DBITS), .CNT_BITS(CNT_BITS)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );
   always #5 clk = ~clk;
   function automatic logic [31:0] pat(input logic [31:0] a);
      return (a == 32'h100) ? 32'hDEAD_BEEF : {a[15:0], ~a[15:0]};
   endfunction
   function automatic int sat(input int v);
      return PERF ? ((v > 15) ? 15 : v) : 0;
   endfunction
   // Memory model: one-cycle read latency.
   always @(posedge clk)
      if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= pat(bus.mem_addr);
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic wait_gnt(output int w, output int c);
      w = -1;
      c = 0;
      while (w < 0 && c < 12) begin
         @(posedge clk);
         #1;
         c++;
         if (bus.gnt0 || bus.gnt1) w = bus.gnt1 ? 1 : 0;
      end
   endtask
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic chk_cnt(input string tag);
      chk({tag, "_gcnt0"}, bus.gcnt0, sat(e_g0));
      chk({tag, "_gcnt1"}, bus.gcnt1, sat(e_g1));
      chk({tag, "_ccnt"}, bus.ccnt, sat(e_cc));
   endtask
   // Read-data scoreboard and exclusivity monitor, sampled on the falling edge.
   always @(negedge clk) begin
      rd_t e;
      if (bus.gnt0 || bus.gnt1) chk("gnt_excl", bus.gnt0 & bus.gnt1, 0);
      if (bus.rvalid0 || bus.rvalid1) begin
         chk("rvalid_excl", bus.rvalid0 & bus.rvalid1, 0);
         if (sb.size() == 0) chk("rvalid_unexpected", 1, 0);
         else begin
            e = sb.pop_front();
            chk("rd_owner", bus.rvalid1, e.who);
            chk("rd_data", e.who != 0 ? bus.rdata1 : bus.rdata0, e.data);
            chk("rd_other", e.who != 0 ? bus.rdata0 : bus.rdata1, 0);
         end
      end
   end
   initial begin
      bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
      bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
      step(3);
      reset = 1'b0;
      step(1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_mem_en", bus.mem_en, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_gnt", {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1}, 0);
      chk("rst_rdata", {bus.rdata0, bus.rdata1}, 0);
      chk_cnt("rst");
      // single read by requester 0
      bus.req0 = 1; bus.we0 = 0; bus.addr0 = 32'h100;
      wait_gnt(who, cyc);
      sb.push_back(rd_t'{who: 0, data: 32'hDEAD_BEEF});
      e_g0++;
      chk("rd_gnt_who", who, 0);
      chk("rd_gnt_lat", cyc, 1);
      chk("rd_mem_en", bus.mem_en, 1);
      chk("rd_mem_addr", bus.mem_addr, 32'h100);
      chk("rd_mem_we", bus.mem_we, 0);
      chk("rd_busy", bus.busy, 1);
      bus.req0 = 0;
      step(1);
      chk("rd_rvalid0", bus.rvalid0, 1);
      chk("rd_mem_en_drop", bus.mem_en, 0);
      step(1);
      chk("rd_idle", bus.busy, 0);
      // single write by requester 1
      bus.req1 = 1; bus.we1 = 1; bus.addr1 = 32'hF000_0004; bus.wdata1 = 32'h3FF;
      wait_gnt(who, cyc);
      e_g1++;
      chk("wr_gnt_who", who, 1);
      chk("wr_gnt_lat", cyc, 1);
      chk("wr_mem_we", bus.mem_we, 1);
      chk("wr_mem_wdata", bus.mem_wdata, 32'h3FF);
      chk("wr_mem_addr", bus.mem_addr, 32'hF000_0004);
      bus.req1 = 0;
      step(1);
      chk("wr_idle", bus.busy, 0);
      chk("wr_mem_en_drop", bus.mem_en, 0);
      step(2);
      chk_cnt("pre_ct");
      // contention: both requesters hold read requests
      bus.req0 = 1; bus.we0 = 0; bus.addr0 = 32'h200;
      bus.req1 = 1; bus.we1 = 0; bus.addr1 = 32'h300;
      for (int k = 0; k < 4; k++) begin
         wait_gnt(who, cyc);
         sb.push_back(rd_t'{who: k % 2, data: pat((k % 2) != 0 ? 32'h300 : 32'h200)});
         chk("ct_order", who, k % 2);
         chk("ct_spacing", cyc, k == 0 ? 1 : 3);
         e_cc++;
         if (k % 2 != 0) e_g1++;
         else e_g0++;
      end
      bus.req0 = 0; bus.req1 = 0;
      step(3);
      chk("ct_idle", bus.busy, 0);
      chk_cnt("ct");
      // back-to-back writes from requester 0
      bus.req0 = 1; bus.we0 = 1; bus.addr0 = 32'h400; bus.wdata0 = 32'h11;
      for (int k = 0; k < 3; k++) begin
         wait_gnt(who, cyc);
         e_g0++;
         chk("b2b_who", who, 0);
         chk("b2b_spacing", cyc, k == 0 ? 1 : 2);
         chk("b2b_addr", bus.mem_addr, 32'h400 + 4 * k);
         chk("b2b_wdata", bus.mem_wdata, 32'h11 + k);
         bus.addr0 = 32'h400 + 4 * (k + 1);
         bus.wdata0 = 32'h11 + k + 1;
      end
      bus.req0 = 0;
      step(2);
      chk_cnt("b2b");
      // reset asserted as the read enters RDWAIT
      bus.req0 = 1; bus.we0 = 0; bus.addr0 = 32'h100;
      wait_gnt(who, cyc);
      chk("rr_gnt_who", who, 0);
      bus.req0 = 0;
      @(posedge clk);
      reset = 1'b1;
      #1;
      e_g0 = 0; e_g1 = 0; e_cc = 0;
      chk("rr_busy", bus.busy, 0);
      chk("rr_mem_en", bus.mem_en, 0);
      chk("rr_rvalid0", bus.rvalid0, 0);
      chk("rr_mem_addr", bus.mem_addr, 0);
      chk_cnt("rr");
      step(2);
      reset = 1'b0;
      step(1);
      bus.req0 = 1; bus.we0 = 0; bus.addr0 = 32'h500;
      bus.req1 = 1; bus.we1 = 0; bus.addr1 = 32'h600;
      wait_gnt(who, cyc);
      sb.push_back(rd_t'{who: 0, data: pat(32'h500)});
      e_g0++;
      e_cc++;
      chk("rr_tie_who", who, 0);
      bus.req0 = 0; bus.req1 = 0;
      step(3);
      chk_cnt("rr_tie");
      // saturation: 20 grants to requester 0
      bus.req0 = 1; bus.we0 = 1; bus.addr0 = 32'h700;
      for (int k = 0; k < 20; k++) begin
         wait_gnt(who, cyc);
         e_g0++;
         chk("sat_who", who, 0);
      end
      bus.req0 = 0;
      step(3);
      chk("sat_gcnt0", bus.gcnt0, PERF ? 15 : 0);
      chk_cnt("sat");
      chk("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
